branch_resolution_unit: RTL
===========================

# branch_resolution_unit

Parametrised, pipelined successor to the single-cycle branch comparator in the execute stage. It resolves RV conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) behind a valid/ready handshake and buffers results in a 2-entry output queue. It compares the outcome against the front-end's static prediction and raises misalignment only for taken branches, as the ISA spec requires. It also keeps saturating branch and mispredict counters for performance monitoring.

## Interface
- XLEN, 32, datapath and PC width
- IALIGN, 32, instruction alignment in bits; legal values 32 or 16 (compressed support)
- COUNTER_WIDTH, 32, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_pc  in  XLEN  PC of the branch instruction
- in_subfunction_3  in  3  funct3 of the branch
- in_immediate  in  XLEN  sign-extended B-immediate
- in_rs1_value, in_rs2_value  in  XLEN  operands
- in_predicted_taken  in  1  front-end prediction
- out_valid  out  1  result valid at queue head
- out_ready  in  1  consumer accepts head
- out_taken  out  1  branch condition true
- out_next_pc  out  XLEN  resolved next PC
- out_mispredict  out  1  outcome differs from prediction
- out_error_illegal  out  1  funct3 is 010 or 011
- out_error_misaligned  out  1  taken target misaligned
- counter_clear  in  1  synchronous clear of both counters
- branch_count  out  COUNTER_WIDTH  legal branches retired
- mispredict_count  out  COUNTER_WIDTH  mispredicts retired

## Operation
- Encodings: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111. 010/011 are illegal.
- BLT/BGE compare signed; BLTU/BGEU compare unsigned; all comparisons are at full XLEN.
- target = in_pc + in_immediate; fallthrough = in_pc + 4. Both are computed mod 2^XLEN, so wrap-around is silent.
- Legal branch: out_next_pc = taken ? target : fallthrough.
- Misaligned check applies only when taken. For IALIGN=32 the condition is target[1:0] != 0; for IALIGN=16 it is target[0] != 0.
- When misaligned: out_error_misaligned=1, out_taken=1, out_next_pc=target. A not-taken branch never flags misalignment.
- Illegal funct3: out_error_illegal=1, out_taken=0, out_next_pc=fallthrough, out_mispredict=0.
- out_mispredict = out_taken XOR in_predicted_taken, forced to 0 whenever either error is set.
- Queue: 2-entry FIFO of result records.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (occupancy != 2), decoded from registered occupancy. When the queue is full, a same-cycle pop does not enable a push.
  - out_valid = (occupancy != 0). Head fields hold stable while out_valid && !out_ready.
  - Simultaneous push and pop at occupancy 1 leaves occupancy at 1 and advances the head.
- Counters update on pop only.
  - branch_count increments for legal entries, including misaligned ones.
  - mispredict_count increments when the popped entry has out_mispredict=1.
  - Both counters saturate at all-ones.
  - counter_clear zeroes both counters and takes priority over a same-cycle increment.

## Timing
- Latency 1: a request accepted at edge N is visible at the head from the cycle after edge N, provided the queue was empty.
- Throughput is 1 result per cycle when out_ready is held high.
- Reset values: occupancy 0, out_valid 0, in_ready 1 (also while reset is asserted), all out_* data 0, both counters 0.
- Reset asserted mid-operation drops all queued entries immediately without popping them, so counters do not increment. Counters return to 0.
- in_* fields are sampled only on the accepting edge and are don't-care otherwise.

## Test plan
- BEQ, pc=0x100, imm=0x20, rs1=rs2=5, predicted 0 -> out_taken=1, next_pc=0x120, mispredict=1, mispredict_count=1 after pop.
- BLT, rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, next_pc=pc+4. BGEU with rs1=rs2 -> taken.
- funct3=010, pc=0x200 -> error_illegal=1, next_pc=0x204, branch_count unchanged. BNE taken to 0x102 with IALIGN=32 -> error_misaligned=1. The same target not taken -> no error. With IALIGN=16 the taken branch to 0x102 -> no error.
- Backpressure: out_ready=0 while 3 back-to-back requests are offered.
  - in_ready drops after the 2nd request is accepted; the 3rd is held off.
  - Head stays stable.
  - Releasing out_ready drains the results in order. Also check pc=0xFFFFFFFC, imm=8 -> next_pc=0x4.
- COUNTER_WIDTH=4, pop 17 legal branches -> branch_count=0xF. counter_clear on the same cycle as a pop -> 0.
- Assert reset with 2 queued entries -> out_valid=0, in_ready=1, counters 0 immediately. After reset release, a new BEQ resolves normally.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// Pipelined conditional-branch resolver: computes taken/next-PC/error flags for
// RV branches, buffers results in a 2-entry FIFO and keeps saturating perf counters.
module branch_resolution_unit #(
  parameter int XLEN          = 32,
  parameter int IALIGN        = 32,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [2:0]               in_subfunction_3,
  input  logic [XLEN-1:0]          in_immediate,
  input  logic [XLEN-1:0]          in_rs1_value,
  input  logic [XLEN-1:0]          in_rs2_value,
  input  logic                     in_predicted_taken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_taken,
  output logic [XLEN-1:0]          out_next_pc,
  output logic                     out_mispredict,
  output logic                     out_error_illegal,
  output logic                     out_error_misaligned,
  input  logic                     counter_clear,
  output logic [COUNTER_WIDTH-1:0] branch_count,
  output logic [COUNTER_WIDTH-1:0] mispredict_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on valid in the same cycle, and a producer holding
  // valid keeps its payload until the transfer.

  // ---------------- combinational resolution ----------------
  logic            cond;
  logic            illegal;
  logic            misaligned;
  logic            mispredict;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    cond        = 1'b0;
    illegal     = 1'b0;
    target      = in_pc + in_immediate;
    fallthrough = in_pc + XLEN'(4);
    case (in_subfunction_3)
      3'b000:  cond = (in_rs1_value == in_rs2_value);
      3'b001:  cond = (in_rs1_value != in_rs2_value);
      3'b100:  cond = ($signed(in_rs1_value) <  $signed(in_rs2_value));
      3'b101:  cond = ($signed(in_rs1_value) >= $signed(in_rs2_value));
      3'b110:  cond = (in_rs1_value <  in_rs2_value);
      3'b111:  cond = (in_rs1_value >= in_rs2_value);
      default: illegal = 1'b1;
    endcase
    // Alignment only matters when the target is actually fetched.
    if (IALIGN == 16) misaligned = cond && target[0];
    else              misaligned = cond && (target[1:0] != 2'b00);
    next_pc    = cond ? target : fallthrough;
    mispredict = (cond ^ in_predicted_taken) && !illegal && !misaligned;
  end

  // ---------------- 2-entry result FIFO ----------------
  logic            q_taken   [2];
  logic            q_mispred [2];
  logic            q_illegal [2];
  logic            q_misalign[2];
  logic [XLEN-1:0] q_next_pc [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occupancy;
  logic            push;
  logic            pop;

  assign in_ready  = (occupancy != 2'd2);
  assign out_valid = (occupancy != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        q_taken[i]    <= 1'b0;
        q_mispred[i]  <= 1'b0;
        q_illegal[i]  <= 1'b0;
        q_misalign[i] <= 1'b0;
        q_next_pc[i]  <= '0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        q_taken[wr_ptr]    <= cond;
        q_mispred[wr_ptr]  <= mispredict;
        q_illegal[wr_ptr]  <= illegal;
        q_misalign[wr_ptr] <= misaligned;
        q_next_pc[wr_ptr]  <= next_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign out_taken            = q_taken[rd_ptr];
  assign out_next_pc          = q_next_pc[rd_ptr];
  assign out_mispredict       = q_mispred[rd_ptr];
  assign out_error_illegal    = q_illegal[rd_ptr];
  assign out_error_misaligned = q_misalign[rd_ptr];

  // ---------------- performance counters (retire on pop) ----------------
  logic count_branch;
  logic count_mispredict;

  assign count_branch     = pop && !q_illegal[rd_ptr];
  assign count_mispredict = pop && q_mispred[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (counter_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (count_branch && (branch_count != '1))
        branch_count <= branch_count + COUNTER_WIDTH'(1);
      if (count_mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + COUNTER_WIDTH'(1);
    end
  end

endmodule
